// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle arithmetic, logic and shift ops,
// plus N-cycle unsigned shift-add multiply and restoring divide.
//
// Parameter: N            operand/result width (N >= 4)
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous active-high reset
//   start                 request; accepted only while busy=0
//   cntrl[3:0]            op select, sampled with start
//   in1[N-1:0]            first operand / shifted value / dividend
//   in2[N-1:0]            second operand / shift amount / divisor
//   busy                  high while MUL/DIV iterates
//   done                  one-cycle pulse, out/rem/flags valid
//   out[N-1:0]            registered result
//   rem[N-1:0]            registered DIV remainder, 0 otherwise
//   V, Z, S, cout         overflow, zero, sign, carry/borrow flags
module alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   cntrl,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out,
  output logic [N-1:0] rem,
  output logic         V,
  output logic         Z,
  output logic         S,
  output logic         cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_CMPL = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic [N-1:0]  opb;
  logic [N-1:0]  acc;
  logic [N-1:0]  ql;

  logic          mul_op;
  logic [N-1:0]  res;
  logic          rc;
  logic          rv;
  logic [N:0]    add_s;
  logic [N:0]    sub_d;
  logic [N:0]    sll_x;
  logic [N:0]    srx;
  logic [N-1:0]  sra_r;

  logic [N:0]    msum;
  logic [N:0]    dsh;
  logic [N+1:0]  ddif;
  logic [N-1:0]  acc_n;
  logic [N-1:0]  ql_n;
  logic          unused_ok;

  assign mul_op = (cntrl == OP_MUL) || (cntrl == OP_DIV);

  assign add_s = {1'b0, in1} + {1'b0, in2};
  // Top bit of the difference is the unsigned borrow.
  assign sub_d = {1'b0, in1} - {1'b0, in2};

  // One guard bit catches the last bit shifted out. It reads 0 for
  // amount 0 and for amounts beyond N, with no special casing.
  assign sll_x = {1'b0, in1} << in2;
  assign srx   = {in1, 1'b0} >> in2;
  assign sra_r = $unsigned($signed(in1) >>> in2);

  always_comb begin
    res = '0;
    rc  = 1'b0;
    rv  = 1'b0;
    unique case (cntrl)
      OP_ADD: begin
        res = add_s[N-1:0];
        rc  = add_s[N];
        rv  = (in1[N-1] ~^ in2[N-1])
            & (add_s[N-1] ^ in1[N-1]);
      end
      OP_SUB: begin
        res = sub_d[N-1:0];
        rc  = sub_d[N];
        rv  = (in1[N-1] ^ in2[N-1])
            & (sub_d[N-1] ^ in1[N-1]);
      end
      OP_OR:   res = in1 | in2;
      OP_AND:  res = in1 & in2;
      OP_SLL: begin
        res = sll_x[N-1:0];
        rc  = sll_x[N];
      end
      OP_SRL: begin
        res = srx[N:1];
        rc  = srx[0];
      end
      OP_SRA: begin
        res = sra_r;
        rc  = srx[0];
      end
      OP_CMPL: res = ~in1;
      OP_PASS: res = in1;
      default: ;
    endcase
  end

  // One iteration of the multi-cycle datapath.
  // MUL: acc:ql is the 2N-bit product, ql starts as multiplier.
  // DIV: acc is the partial remainder, ql shifts dividend out and
  // quotient in.
  assign msum = {1'b0, acc}
              + (ql[0] ? {1'b0, opb} : '0);
  assign dsh  = {acc, ql[N-1]};
  assign ddif = {1'b0, dsh} - {2'b0, opb};

  always_comb begin
    acc_n = msum[N:1];
    ql_n  = {msum[0], ql[N-1:1]};
    if (is_div) begin
      if (!ddif[N+1]) begin
        acc_n = ddif[N-1:0];
        ql_n  = {ql[N-2:0], 1'b1};
      end else begin
        acc_n = dsh[N-1:0];
        ql_n  = {ql[N-2:0], 1'b0};
      end
    end
  end

  // A restoring step never leaves a remainder >= divisor,
  // so bit N of the difference carries no information.
  assign unused_ok = ddif[N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      ql     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      rem    <= '0;
      V      <= 1'b0;
      Z      <= 1'b0;
      S      <= 1'b0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (mul_op) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= (cntrl == OP_DIV);
              opb    <= in2;
              acc    <= '0;
              ql     <= in1;
            end else begin
              out  <= res;
              rem  <= '0;
              V    <= rv;
              cout <= rc;
              Z    <= (res == '0);
              S    <= res[N-1];
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_n;
          ql  <= ql_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Divide by zero needs no override for out/rem:
            // every trial subtract succeeds, giving all-ones
            // quotient and the dividend as remainder.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            out   <= ql_n;
            rem   <= is_div ? acc_n : '0;
            V     <= is_div ? (opb == '0)
                            : (acc_n != '0);
            cout  <= 1'b0;
            Z     <= (ql_n == '0);
            S     <= ql_n[N-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (N=8).
// Expected results are queued at issue and compared at each done.
module tb_alu_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   cntrl = '0;
  logic [N-1:0] in1 = '0;
  logic [N-1:0] in2 = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic [N-1:0] rem;
  logic         V;
  logic         Z;
  logic         S;
  logic         cout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] o;
    logic [7:0] r;
    logic       v;
    logic       z;
    logic       s;
    logic       c;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  alu_seq #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .cntrl(cntrl),
    .in1  (in1),
    .in2  (in2),
    .busy (busy),
    .done (done),
    .out  (out),
    .rem  (rem),
    .V    (V),
    .Z    (Z),
    .S    (S),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag,
                                 input logic [3:0] c,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
    int ai, bi, r, sa, sb, sr;
    ai = a;
    bi = b;
    r = 0;
    sa = a[7] ? ai - 256 : ai;
    sb = b[7] ? bi - 256 : bi;
    e.tag = tag;
    e.r = 8'h00;
    e.v = 1'b0;
    e.c = 1'b0;
    case (c)
      4'd0: begin
        r = ai + bi;
        e.c = (r > 255);
        r = r & 255;
        sr = sa + sb;
        e.v = (sr > 127) || (sr < -128);
      end
      4'd1: begin
        e.c = (ai < bi);
        r = (ai - bi) & 255;
        sr = sa - sb;
        e.v = (sr > 127) || (sr < -128);
      end
      4'd2: r = ai | bi;
      4'd3: r = ai & bi;
      4'd4: begin
        if (bi < 8) r = (ai << bi) & 255;
        if (bi >= 1 && bi <= 8) e.c = a[8-bi];
      end
      4'd5: begin
        if (bi < 8) r = ai >> bi;
        if (bi >= 1 && bi <= 8) e.c = a[bi-1];
      end
      4'd6: r = (~ai) & 255;
      4'd7: r = ai;
      4'd8: begin
        r = ai * bi;
        e.v = ((r >> 8) != 0);
        r = r & 255;
      end
      4'd9: begin
        if (bi == 0) begin
          r = 255;
          e.r = a;
          e.v = 1'b1;
        end else begin
          r = ai / bi;
          e.r = 8'(ai % bi);
        end
      end
      4'd10: begin
        if (bi < 8) begin
          r = ai >> bi;
          if (a[7]) r = r | ((255 << (8 - bi)) & 255);
        end else begin
          r = a[7] ? 255 : 0;
        end
        if (bi >= 1 && bi <= 8) e.c = a[bi-1];
      end
      default: r = 0;
    endcase
    e.o = 8'(r);
    e.z = (r == 0);
    e.s = e.o[7];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'(done), 0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.tag, ".out"}, 32'(out), 32'(mon_e.o));
        chk({mon_e.tag, ".rem"}, 32'(rem), 32'(mon_e.r));
        chk({mon_e.tag, ".V"}, 32'(V), 32'(mon_e.v));
        chk({mon_e.tag, ".Z"}, 32'(Z), 32'(mon_e.z));
        chk({mon_e.tag, ".S"}, 32'(S), 32'(mon_e.s));
        chk({mon_e.tag, ".cout"}, 32'(cout), 32'(mon_e.c));
      end
    end
  end

  task automatic issue(input string tag,
                       input logic [3:0] c,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input bit push);
    @(negedge clk);
    start = 1'b1;
    cntrl = c;
    in1 = a;
    in2 = b;
    if (push) sbq.push_back(model(tag, c, a, b));
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic one(input string tag,
                     input logic [3:0] c,
                     input logic [7:0] a,
                     input logic [7:0] b);
    issue(tag, c, a, b, 1'b1);
    idle();
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 0);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20; k++) begin
      if (!busy && sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("idle_bound", 32'(k < 20), 1);
  endtask

  initial begin
    logic [3:0] rc;
    logic [7:0] ra, rb;

    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.out", 32'(out), 0);
    chk("rst.rem", 32'(rem), 0);
    chk("rst.V", 32'(V), 0);
    chk("rst.Z", 32'(Z), 0);
    chk("rst.S", 32'(S), 0);
    chk("rst.cout", 32'(cout), 0);
    rst = 1'b0;

    one("add7f_01", 4'd0, 8'h7F, 8'h01);
    one("sub00_01", 4'd1, 8'h00, 8'h01);
    one("sra80_3", 4'd10, 8'h80, 8'h03);
    one("sll81_8", 4'd4, 8'h81, 8'h08);
    one("addff_01", 4'd0, 8'hFF, 8'h01);
    one("sub80_01", 4'd1, 8'h80, 8'h01);
    one("or", 4'd2, 8'hA0, 8'h05);
    one("and", 4'd3, 8'hF0, 8'h3C);
    one("srl_3", 4'd5, 8'hB5, 8'h03);
    one("srl_9", 4'd5, 8'hB5, 8'h09);
    one("sll_0", 4'd4, 8'hB5, 8'h00);
    one("sra_9", 4'd10, 8'h91, 8'h09);
    one("sra_8", 4'd10, 8'h91, 8'h08);
    one("cmpl", 4'd6, 8'h5A, 8'h00);
    one("pass", 4'd7, 8'hC3, 8'h11);
    one("op12", 4'd12, 8'hC3, 8'h11);

    issue("mul10_10", 4'd8, 8'h10, 8'h10, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mul.busy", 32'(busy), 1);
      chk("mul.nodone", 32'(done), 0);
      start = (i == 2);
      cntrl = 4'd0;
      in1 = 8'h01;
      in2 = 8'h01;
    end
    @(negedge clk);
    chk("mul.busy_clr", 32'(busy), 0);
    chk("mul.done", 32'(done), 1);
    @(negedge clk);
    chk("mul.pulse", 32'(done), 0);

    issue("div64_07", 4'd9, 8'h64, 8'h07, 1'b1);
    idle();
    wait_idle();
    issue("div55_00", 4'd9, 8'h55, 8'h00, 1'b1);
    idle();
    wait_idle();
    issue("mulff_ff", 4'd8, 8'hFF, 8'hFF, 1'b1);
    idle();
    wait_idle();

    issue("b2b_add", 4'd0, 8'h12, 8'h34, 1'b1);
    issue("b2b_sub", 4'd1, 8'h10, 8'h20, 1'b1);
    issue("b2b_sll", 4'd4, 8'h0F, 8'h02, 1'b1);
    idle();
    chk("b2b.done3", 32'(done), 1);
    @(negedge clk);
    chk("b2b.pulse", 32'(done), 0);

    one("add5_6", 4'd0, 8'h05, 8'h06);
    issue("mul_abort", 4'd8, 8'h03, 8'h05, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.out", 32'(out), 0);
    chk("abort.Z", 32'(Z), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort.idle", 32'(busy), 0);
    one("add1_1", 4'd0, 8'h01, 8'h01);

    for (int i = 0; i < 30; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        rb = 8'($urandom_range(0, 10));
      else
        rb = 8'($urandom);
      if (rc == 4'd8 || rc == 4'd9) begin
        issue("rnd_md", rc, ra, rb, 1'b1);
        idle();
        wait_idle();
      end else begin
        one("rnd", rc, ra, rb);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (N >= 4).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation, sampled on clk rising edge.
REQ-005 cntrl  input  4  operation select, sampled with start.
REQ-006 in1  input  N  first operand (accumulator side), sampled with start.
REQ-007 in2  input  N  second operand or shift amount, sampled with start.
REQ-008 busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 done  output  1  one-cycle pulse, result and flags valid.
REQ-010 out  output  N  registered result.
REQ-011 rem  output  N  registered division remainder, 0 for all other ops.
REQ-012 V, Z, S, cout  output  1 each  overflow, zero, sign, carry/borrow flags, registered.

Function
REQ-013 Ops: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLL, 5 SRL, 6 CMPL (~in1), 7 PASS (in1), 8 MUL, 9 DIV, 10 SRA; codes 11-15 give out=0, rem=0, V=0, cout=0.
REQ-014 Request accepted only on an edge with start=1 and busy=0; start while busy=1 is ignored, with no effect on state or outputs.
REQ-015 Single-cycle ops (all except 8, 9) register out/flags on the accepting edge; done=1 for the following cycle only; busy stays 0.
REQ-016 FSM states IDLE, RUN, with IDLE->RUN on accepted MUL/DIV, RUN->IDLE after N iteration edges, RUN ignores start.
REQ-017 MUL/DIV: busy=1 from accepting edge; results/flags/done update on the Nth edge after acceptance, which also clears busy; latency N cycles.
REQ-018 Back-to-back single-cycle ops on consecutive edges are accepted; done stays high continuously.
REQ-019 ADD: {cout,out}=in1+in2 (N+1 bits); V=signed overflow (carry into MSB XOR carry out).
REQ-020 SUB: out=in1-in2 mod 2^N; cout=1 when in1<in2 unsigned (borrow); V=signed overflow.
REQ-021 Shifts: in2 unsigned amount; cout=last bit shifted out, 0 when amount=0 or amount>N.
REQ-022 Shifts with amount >= N: SLL/SRL give out=0; SRA gives all bits equal to in1[N-1].
REQ-023 SRA fills vacated bits with in1[N-1].
REQ-024 MUL: unsigned shift-add, 1 bit per cycle; out=low N bits of product; V=1 when high N bits nonzero; cout=0.
REQ-025 DIV: unsigned restoring, 1 quotient bit per cycle; out=quotient, rem=remainder, V=0, cout=0.
REQ-026 DIV by zero: out=all ones, rem=in1, V=1; done still after N cycles.
REQ-027 Z=1 when registered out==0; S=out[N-1]; logic/CMPL/PASS ops give V=0, cout=0.
REQ-028 Outputs hold their values between done pulses; operands are latched internally, so in1/in2/cntrl changes during RUN have no effect.

Reset
REQ-029 While rst=1, regardless of clk: FSM=IDLE; busy, done, out, rem, V, Z, S, cout = 0.
REQ-030 Reset during RUN aborts the operation with no done pulse; first accepted start after rst falls behaves normally.
REQ-031 Z resets to 0 (not derived from out) until the first done.

Verification
REQ-032 N=8, ADD 0x7F+0x01 -> next cycle out=0x80, V=1, cout=0, Z=0, S=1, done one cycle.
REQ-033 SUB 0x00-0x01 -> out=0xFF, cout=1, V=0; then SRA 0x80 by 3 -> out=0xF0, cout=0; SLL 0x81 by 8 -> out=0x00, cout=1, Z=1.
REQ-034 MUL 0x10*0x10 with start re-asserted (ADD) mid-run -> busy 8 cycles, ADD ignored, out=0x00, V=1, Z=1, done on 8th edge.
REQ-035 DIV 0x64/0x07 -> out=0x0E, rem=0x02, V=0 after 8 cycles; DIV 0x55/0x00 -> out=0xFF, rem=0x55, V=1.
REQ-036 rst asserted asynchronously at 4th cycle of MUL -> busy/done/out clear immediately, no done; subsequent ADD 0x01+0x01 -> out=0x02.
REQ-037 Consecutive single-cycle ops on 3 back-to-back edges -> done high 3 cycles, each result correct in order.
